rs544522_cw_assembler: RTL and testbench

//  Downstream companion of the RS(544,522) L=8 look-ahead LFSR encoder.
//  - Receives the same front-padded message beats that feed the encoder: 66 beats, 8 symbols each, the first 6 symbols zero.
//  - Buffers those beats until the encoder's 22-symbol parity arrives.
//  - Emits the systematic 544-symbol codeword as exactly 68 beats of 8 symbols, with ready/valid backpressure.
//  - Order on the output: pad stripped, message first, parity rem[21] first.

---
 rtl/rs544522_pkg.sv | 28 ++
 rtl/rs_sync_fifo.sv | 59 +++++
 rtl/rs544522_cw_assembler.sv | 200 ++++++++++++++++++++
 tb/tb_rs544522_cw_assembler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs544522_pkg.sv
// Shared constants, types and FSM encoding for the RS(544,522) codeword
// assembler. Symbols are GF(2^10); a beat carries L symbols, lane 0 in the
// least significant bits.
package rs544522_pkg;

    localparam int W           = 10;
    localparam int L           = 8;
    localparam int R           = 22;
    localparam int N_IN_BEATS  = 66;
    localparam int N_OUT_BEATS = 68;
    localparam int PAD         = 6;

    // Output beats 0..64 are built from message data; 65..67 carry parity.
    localparam int LAST_MSG_BEAT = N_IN_BEATS - 2;

    typedef logic [W-1:0] sym_t;
    typedef sym_t [L-1:0] blk_t;
    typedef sym_t [R-1:0] par_t;

    typedef enum logic [2:0] {
        S_PRIME,
        S_MSG,
        S_PAR0,
        S_PAR1,
        S_PAR2
    } asm_state_e;

endpackage

// File: rtl/rs_sync_fifo.sv
// Generic show-ahead synchronous FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears pointers)
//   wr_en_i/wr_data_i : push; dropped when full unless a pop frees a slot
//   rd_en_i      : pop (ignored when empty)
//   rd_data_o    : head entry, valid whenever !empty_o
//   empty_o, full_o : status
//   drop_o       : a push was discarded this cycle
// DEPTH must be a power of two so the pointers wrap naturally.
module rs_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             rd_ok;
    logic             wr_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign rd_ok     = rd_en_i && !empty_o;
    assign wr_ok     = wr_en_i && (!full_o || rd_ok);
    assign drop_o    = wr_en_i && !wr_ok;
    assign rd_data_o = mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rs544522_cw_assembler.sv
// Rebuilds the systematic RS(544,522) codeword from the padded message beats
// and the encoder parity, emitting 68 beats of 8 symbols with ready/valid.
//   msg_valid_i/msg_last_i/msg_blk_i : padded message beats (cannot stall)
//   msg_ready_o   : message FIFO not full (status)
//   parity_valid_i/parity_i : parity vector rem[0..21]
//   cw_valid_o/cw_ready_i/cw_sop_o/cw_eop_o/cw_blk_o : codeword stream
//   ovf_o         : sticky FIFO overflow
// Optional macro RS544_ASM_FRAME_CHECK_EN adds frame_err_o (sticky framing error).
//
// state   | meaning
// S_PRIME | pop padded beat 0 into the hold register, no output
// S_MSG   | emit beats 0..64 from hold lanes plus next beat lanes 0..5
// S_PAR0  | wait for parity, emit hold lanes + par[21..16]
// S_PAR1  | emit par[15..8]
// S_PAR2  | emit par[7..0], pop parity
module rs544522_cw_assembler
    import rs544522_pkg::*;
#(
    parameter int MSG_DEP = 128,
    parameter int PAR_DEP = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             msg_valid_i,
    input  logic             msg_last_i,
    input  logic [L*W-1:0]   msg_blk_i,
    output logic             msg_ready_o,
    input  logic             parity_valid_i,
    input  logic [R*W-1:0]   parity_i,
    output logic             cw_valid_o,
    input  logic             cw_ready_i,
    output logic             cw_sop_o,
    output logic             cw_eop_o,
    output logic [L*W-1:0]   cw_blk_o,
    output logic             ovf_o
`ifdef RS544_ASM_FRAME_CHECK_EN
    ,
    output logic             frame_err_o
`endif
);
    asm_state_e    state_q, state_d;
    logic [6:0]    bcnt_q, bcnt_d;
    sym_t [1:0]    hold_q;
    blk_t          out_blk_q, out_blk_d;
    logic          out_sop_d, out_eop_d, out_ld, out_free;
    logic          hold_ld, msg_pop, par_pop;
    logic          msg_empty, msg_full, msg_drop;
    logic          par_empty, par_drop;
    logic [L*W-1:0] msg_rdata;
    logic [R*W-1:0] par_rdata;
    blk_t          msg_head;
    par_t          par_head;

    rs_sync_fifo #(.WIDTH(L*W), .DEPTH(MSG_DEP)) u_msg_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (msg_valid_i),
        .wr_data_i (msg_blk_i),
        .rd_en_i   (msg_pop),
        .rd_data_o (msg_rdata),
        .empty_o   (msg_empty),
        .full_o    (msg_full),
        .drop_o    (msg_drop)
    );

    rs_sync_fifo #(.WIDTH(R*W), .DEPTH(PAR_DEP)) u_par_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (parity_valid_i),
        .wr_data_i (parity_i),
        .rd_en_i   (par_pop),
        .rd_data_o (par_rdata),
        .empty_o   (par_empty),
        .full_o    (),
        .drop_o    (par_drop)
    );

    assign msg_head    = msg_rdata;
    assign par_head    = par_rdata;
    assign msg_ready_o = !msg_full;
    assign cw_blk_o    = out_blk_q;
    // Output register may take a new beat when empty or being drained now.
    assign out_free    = !cw_valid_o || cw_ready_i;

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        msg_pop   = 1'b0;
        par_pop   = 1'b0;
        hold_ld   = 1'b0;
        out_ld    = 1'b0;
        out_blk_d = '0;
        out_sop_d = 1'b0;
        out_eop_d = 1'b0;
        case (state_q)
            S_PRIME: begin
                bcnt_d = '0;
                if (!msg_empty) begin
                    msg_pop = 1'b1;
                    hold_ld = 1'b1;
                    state_d = S_MSG;
                end
            end
            S_MSG: begin
                if (!msg_empty && out_free) begin
                    msg_pop      = 1'b1;
                    hold_ld      = 1'b1;
                    out_ld       = 1'b1;
                    out_blk_d[0] = hold_q[0];
                    out_blk_d[1] = hold_q[1];
                    for (int i = 0; i < PAD; i++) out_blk_d[2+i] = msg_head[i];
                    out_sop_d    = (bcnt_q == '0);
                    bcnt_d       = bcnt_q + 7'd1;
                    if (bcnt_q == 7'(LAST_MSG_BEAT)) state_d = S_PAR0;
                end
            end
            S_PAR0: begin
                if (!par_empty && out_free) begin
                    out_ld       = 1'b1;
                    out_blk_d[0] = hold_q[0];
                    out_blk_d[1] = hold_q[1];
                    for (int i = 0; i < PAD; i++) out_blk_d[2+i] = par_head[R-1-i];
                    state_d      = S_PAR1;
                end
            end
            S_PAR1: begin
                if (out_free) begin
                    out_ld = 1'b1;
                    for (int i = 0; i < L; i++) out_blk_d[i] = par_head[R-1-PAD-i];
                    state_d = S_PAR2;
                end
            end
            S_PAR2: begin
                if (out_free) begin
                    out_ld    = 1'b1;
                    par_pop   = 1'b1;
                    out_eop_d = 1'b1;
                    for (int i = 0; i < L; i++) out_blk_d[i] = par_head[L-1-i];
                    state_d   = S_PRIME;
                end
            end
            default: state_d = S_PRIME;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_PRIME;
            bcnt_q     <= '0;
            hold_q     <= '0;
            out_blk_q  <= '0;
            cw_valid_o <= 1'b0;
            cw_sop_o   <= 1'b0;
            cw_eop_o   <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            if (hold_ld) hold_q <= {msg_head[L-1], msg_head[L-2]};
            if (out_ld) begin
                cw_valid_o <= 1'b1;
                cw_sop_o   <= out_sop_d;
                cw_eop_o   <= out_eop_d;
                out_blk_q  <= out_blk_d;
            end else if (cw_ready_i) begin
                cw_valid_o <= 1'b0;
                cw_sop_o   <= 1'b0;
                cw_eop_o   <= 1'b0;
            end
            if (msg_drop || par_drop) ovf_o <= 1'b1;
        end
    end

`ifdef RS544_ASM_FRAME_CHECK_EN
    logic [6:0] in_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_cnt_q    <= '0;
            frame_err_o <= 1'b0;
        end else if (msg_valid_i) begin
            if (in_cnt_q == 7'(N_IN_BEATS-1)) begin
                in_cnt_q <= '0;
                if (!msg_last_i) frame_err_o <= 1'b1;
            end else if (msg_last_i) begin
                // Early last: flag it and resynchronise on the next beat.
                in_cnt_q    <= '0;
                frame_err_o <= 1'b1;
            end else begin
                in_cnt_q <= in_cnt_q + 7'd1;
            end
            if (in_cnt_q == '0 && msg_blk_i[PAD*W-1:0] != '0) frame_err_o <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = msg_last_i;
`endif

endmodule

// File: tb/tb_rs544522_cw_assembler.sv
module tb_rs544522_cw_assembler;
    import rs544522_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             msg_valid_i = 1'b0;
    logic             msg_last_i = 1'b0;
    logic [L*W-1:0]   msg_blk_i = '0;
    logic             msg_ready_o;
    logic             parity_valid_i = 1'b0;
    logic [R*W-1:0]   parity_i = '0;
    logic             cw_valid_o;
    logic             cw_ready_i = 1'b1;
    logic             cw_sop_o;
    logic             cw_eop_o;
    logic [L*W-1:0]   cw_blk_o;
    logic             ovf_o;
`ifdef RS544_ASM_FRAME_CHECK_EN
    logic             frame_err_o;
`endif

    rs544522_cw_assembler dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .msg_valid_i    (msg_valid_i),
        .msg_last_i     (msg_last_i),
        .msg_blk_i      (msg_blk_i),
        .msg_ready_o    (msg_ready_o),
        .parity_valid_i (parity_valid_i),
        .parity_i       (parity_i),
        .cw_valid_o     (cw_valid_o),
        .cw_ready_i     (cw_ready_i),
        .cw_sop_o       (cw_sop_o),
        .cw_eop_o       (cw_eop_o),
        .cw_blk_o       (cw_blk_o),
        .ovf_o          (ovf_o)
`ifdef RS544_ASM_FRAME_CHECK_EN
        ,
        .frame_err_o    (frame_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [L*W-1:0] blk;
        bit             sop;
        bit             eop;
    } beat_t;

    typedef struct {
        int             beat;
        logic [L*W-1:0] blk;
        bit             sop;
        bit             eop;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] msgs [4][522];
    logic [W-1:0] pars [4][22];
    int           gap_a [4];
    int           pdel_a [4];
    beat_t        exp_q [$];
    vec_t         vecs [6];

    logic [L*W-1:0] cap_blk [68];
    bit             cap_sop [68];
    bit             cap_eop [68];
    int             cap_n = 0;
    int             n_acc = 0;
    int             first_vld_cyc = -1;
    int             wr1_cyc = 0;
    bit             mon_en = 1'b1;
    bit             stall_pend = 1'b0;
    logic [L*W+1:0] stall_val = '0;
    int             rdy_mode = 0;
    int             rdy_ph = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [L*W-1:0] pk_seq(input int first, input int step);
        logic [L*W-1:0] r;
        r = '0;
        for (int j = 0; j < L; j++) r[j*W +: W] = W'(first + j*step);
        return r;
    endfunction

    function automatic logic [L*W-1:0] pad_beat(input int m, input int j);
        logic [L*W-1:0] r;
        int q;
        r = '0;
        for (int l = 0; l < L; l++) begin
            q = j*L + l;
            r[l*W +: W] = (q < PAD) ? '0 : msgs[m][q-PAD];
        end
        return r;
    endfunction

    function automatic logic [R*W-1:0] par_vec(input int m);
        logic [R*W-1:0] r;
        for (int k = 0; k < R; k++) r[k*W +: W] = pars[m][k];
        return r;
    endfunction

    // Reference: flat 544-symbol codeword, then sliced into 68 beats.
    task automatic push_expected(input int m);
        logic [W-1:0] cw [544];
        beat_t e;
        for (int p = 0; p < 522; p++) cw[p] = msgs[m][p];
        for (int k = 0; k < R; k++) cw[522+k] = pars[m][R-1-k];
        for (int b = 0; b < N_OUT_BEATS; b++) begin
            for (int j = 0; j < L; j++) e.blk[j*W +: W] = cw[b*L + j];
            e.sop = (b == 0);
            e.eop = (b == N_OUT_BEATS-1);
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0: cw_ready_i = 1'b1;
            1: begin
                cw_ready_i = (rdy_ph == 0) || (rdy_ph == 3);
                rdy_ph = (rdy_ph + 1) % 4;
            end
            2: cw_ready_i = ($urandom_range(3) != 0);
            default: cw_ready_i = 1'b0;
        endcase
    end

    always @(negedge clk_i) begin
        beat_t e;
        if (!rst_ni) begin
            stall_pend = 1'b0;
        end else if (mon_en) begin
            if (cw_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (stall_pend) begin
                if (!cw_valid_o) chk("valid_dropped_in_stall", 96'(cw_valid_o), 96'd1);
                else chk("stall_hold", 96'({cw_sop_o, cw_eop_o, cw_blk_o}), 96'(stall_val));
            end
            stall_pend = cw_valid_o && !cw_ready_i;
            stall_val  = {cw_sop_o, cw_eop_o, cw_blk_o};
            if (cw_valid_o && cw_ready_i) begin
                n_acc++;
                if (cap_n < 68) begin
                    cap_blk[cap_n] = cw_blk_o;
                    cap_sop[cap_n] = cw_sop_o;
                    cap_eop[cap_n] = cw_eop_o;
                end
                cap_n++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: actual %0h required none", cw_blk_o);
                end else begin
                    n_cmp--;
                    e = exp_q.pop_front();
                    chk("beat_data", 96'(cw_blk_o), 96'(e.blk));
                    chk("beat_sop_eop", 96'({cw_sop_o, cw_eop_o}), 96'({e.sop, e.eop}));
                end
            end
        end
    end

    task automatic idle_inputs();
        msg_valid_i    = 1'b0;
        msg_last_i     = 1'b0;
        msg_blk_i      = '0;
        parity_valid_i = 1'b0;
        parity_i       = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        exp_q.delete();
        repeat (3) @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_stream(input int n, input int abort_at);
        int st [4];
        int t_end;
        bit done;
        done = 1'b0;
        st[0] = 0;
        for (int m = 1; m < n; m++) st[m] = st[m-1] + N_IN_BEATS + gap_a[m-1];
        t_end = 0;
        for (int m = 0; m < n; m++) begin
            if (st[m] + N_IN_BEATS - 1 + pdel_a[m] > t_end) t_end = st[m] + N_IN_BEATS - 1 + pdel_a[m];
            push_expected(m);
        end
        for (int t = 0; t <= t_end && !done; t++) begin
            idle_inputs();
            for (int m = 0; m < n; m++) begin
                if (t >= st[m] && t < st[m] + N_IN_BEATS) begin
                    msg_valid_i = 1'b1;
                    msg_last_i  = (t - st[m] == N_IN_BEATS - 1);
                    msg_blk_i   = pad_beat(m, t - st[m]);
                end
                if (t == st[m] + N_IN_BEATS - 1 + pdel_a[m]) begin
                    parity_valid_i = 1'b1;
                    parity_i       = par_vec(m);
                end
            end
            @(posedge clk_i);
            #1;
            if (t == 1) wr1_cyc = cyc;
            if (abort_at > 0 && n_acc >= abort_at) begin
                rst_ni = 1'b0;
                #1;
                chk("rst_valid", 96'(cw_valid_o), 96'd0);
                chk("rst_sop_eop", 96'({cw_sop_o, cw_eop_o}), 96'd0);
                chk("rst_blk", 96'(cw_blk_o), 96'd0);
                chk("rst_ovf", 96'(ovf_o), 96'd0);
                chk("rst_msg_ready", 96'(msg_ready_o), 96'd1);
                done = 1'b1;
            end
        end
        idle_inputs();
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk_i);
            #1;
        end
        chk(nm, 96'(exp_q.size()), 96'd0);
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic check_table(input string tag);
        int ns, ne;
        chk({tag, "_beats"}, 96'(cap_n), 96'd68);
        for (int v = 0; v < 6; v++) begin
            chk($sformatf("%s_beat%0d", tag, vecs[v].beat), 96'(cap_blk[vecs[v].beat]), 96'(vecs[v].blk));
            chk($sformatf("%s_flags%0d", tag, vecs[v].beat),
                96'({cap_sop[vecs[v].beat], cap_eop[vecs[v].beat]}), 96'({vecs[v].sop, vecs[v].eop}));
        end
        ns = 0;
        ne = 0;
        for (int b = 0; b < 68; b++) begin
            ns += int'(cap_sop[b]);
            ne += int'(cap_eop[b]);
        end
        chk({tag, "_sop_count"}, 96'(ns), 96'd1);
        chk({tag, "_eop_count"}, 96'(ne), 96'd1);
    endtask

    task automatic load_counting_msg();
        for (int i = 0; i < 522; i++) msgs[0][i] = W'(i);
        for (int k = 0; k < R; k++) pars[0][k] = W'(700 + k);
        gap_a[0]  = 0;
        pdel_a[0] = 8;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0,  pk_seq(0, 1),   1'b1, 1'b0};
        vecs[1] = '{1,  pk_seq(8, 1),   1'b0, 1'b0};
        vecs[2] = '{64, pk_seq(512, 1), 1'b0, 1'b0};
        vecs[3] = '{65, (pk_seq(721, -1) << (2*W)) | (L*W)'(520) | ((L*W)'(521) << W), 1'b0, 1'b0};
        vecs[4] = '{66, pk_seq(715, -1), 1'b0, 1'b0};
        vecs[5] = '{67, pk_seq(707, -1), 1'b0, 1'b1};

        rdy_mode = 0;
        do_reset();
        chk("reset_valid", 96'(cw_valid_o), 96'd0);
        chk("reset_sop_eop", 96'({cw_sop_o, cw_eop_o}), 96'd0);
        chk("reset_blk", 96'(cw_blk_o), 96'd0);
        chk("reset_ovf", 96'(ovf_o), 96'd0);
        chk("reset_msg_ready", 96'(msg_ready_o), 96'd1);

        // Counting message, always ready
        load_counting_msg();
        cap_n = 0;
        first_vld_cyc = -1;
        run_stream(1, 0);
        wait_drain("t1_drain");
        check_table("t1");
        chk("t1_latency", 96'(first_vld_cyc - wr1_cyc), 96'd1);

        // Same stimulus, ready 1,0,0,1
        rdy_ph = 0;
        rdy_mode = 1;
        cap_n = 0;
        run_stream(1, 0);
        wait_drain("t2_drain");
        check_table("t2");

        // Three back-to-back random messages, 2-cycle gaps, parity 8 cycles late
        rdy_mode = 0;
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 522; i++) msgs[m][i] = W'($urandom_range(1023));
            for (int k = 0; k < R; k++) pars[m][k] = W'($urandom_range(1023));
            gap_a[m]  = 2;
            pdel_a[m] = 8;
        end
        run_stream(3, 0);
        wait_drain("t3_drain");
        chk("t3_ovf", 96'(ovf_o), 96'd0);

        // Random ready, random gaps and parity delays
        rdy_mode = 2;
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 522; i++) msgs[m][i] = W'($urandom_range(1023));
            for (int k = 0; k < R; k++) pars[m][k] = W'($urandom_range(1023));
            gap_a[m]  = 80 + $urandom_range(20);
            pdel_a[m] = 1 + $urandom_range(19);
        end
        run_stream(4, 0);
        wait_drain("rnd_drain");
        chk("rnd_ovf", 96'(ovf_o), 96'd0);

        // Parity overflow with the output stalled
        rdy_mode = 3;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            parity_valid_i = 1'b1;
            parity_i = {R{W'(s + 1)}};
            @(posedge clk_i);
            #1;
            if (s == 1) chk("t4_ovf_after2", 96'(ovf_o), 96'd0);
        end
        idle_inputs();
        chk("t4_ovf_after3", 96'(ovf_o), 96'd1);
        repeat (5) @(posedge clk_i);
        #1;
        chk("t4_ovf_sticky", 96'(ovf_o), 96'd1);
        do_reset();
        chk("t4_ovf_cleared", 96'(ovf_o), 96'd0);

        // Message FIFO fills: 2 beats drained by prime/first output, 128 held
        for (int j = 0; j < 130; j++) begin
            msg_valid_i = 1'b1;
            msg_blk_i   = (L*W)'({$urandom(), $urandom(), $urandom()});
            @(posedge clk_i);
            #1;
        end
        chk("mfull_ready", 96'(msg_ready_o), 96'd0);
        chk("mfull_ovf_before", 96'(ovf_o), 96'd0);
        @(posedge clk_i);
        #1;
        idle_inputs();
        chk("mfull_ovf_after", 96'(ovf_o), 96'd1);
        do_reset();
        chk("mfull_ready_reset", 96'(msg_ready_o), 96'd1);

        // Reset at output beat 30, then a clean codeword
        rdy_mode = 0;
        do_reset();
        load_counting_msg();
        n_acc = 0;
        run_stream(1, 30);
        do_reset();
        cap_n = 0;
        run_stream(1, 0);
        wait_drain("t5_drain");
        check_table("t5");

`ifdef RS544_ASM_FRAME_CHECK_EN
        mon_en = 1'b0;
        do_reset();
        chk("frame_err_reset", 96'(frame_err_o), 96'd0);
        for (int j = 0; j < 65; j++) begin
            msg_valid_i = 1'b1;
            msg_last_i  = (j == 64);
            msg_blk_i   = pad_beat(0, j);
            @(posedge clk_i);
            #1;
            if (j == 63) chk("frame_err_early", 96'(frame_err_o), 96'd0);
        end
        idle_inputs();
        chk("frame_err_set", 96'(frame_err_o), 96'd1);
        do_reset();
        mon_en = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
